// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every signal the memory port arbiter exchanges with the pipeline
// and with the unified single-port memory.
//   Fetch side : if_req, if_addr        -> arbiter
//                if_rdata, if_ready     <- arbiter
//   Data side  : d_req, d_we, d_addr, d_wdata, d_wstrb -> arbiter
//                d_rdata, d_ready       <- arbiter
//   Stalls     : stall_if, stall_mem    <- arbiter
//   Memory     : mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb <- arbiter
//                mem_rdata              -> arbiter
// The master modport is the arbiter's view; slave is the view of whatever
// surrounds it (pipeline plus memory).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_wstrb;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic              stall_if;
   logic              stall_mem;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_wstrb;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified instruction/data memory between the fetch
// stage and the load/store stage. One access is in flight at a time; each is
// sequenced by a latency counter, its read data is captured into a per-
// requester register, and a one-cycle ready pulse ends it.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, aborts any access in flight
//   bus  - mem_port_arbiter_if.master: fetch/data request channels, stall
//          outputs and the memory-side strobe/address/data signals
// Parameters:
//   MEM_LAT - memory read latency in cycles after the mem_en cycle (1..15)
//   ADDR_W  - address width
//   DATA_W  - data width; the byte strobes are 4 bits, so this must be 32
module mem_port_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

   localparam logic [3:0] LatLast = 4'(MEM_LAT);

   stateT             state;
   stateT             nextState;
   logic [3:0]        cnt;
   logic              ownerD;
   logic              lastGrantD;
   logic              grantValid;
   logic              grantD;
   logic              captureNow;
   logic [ADDR_W-1:0] memAddr;
   logic              memWe;
   logic [DATA_W-1:0] memWdata;
   logic [3:0]        memWstrb;
   logic [DATA_W-1:0] ifRdata;
   logic [DATA_W-1:0] dRdata;
   logic              ifReadyC;
   logic              dReadyC;

   // State register. Reset lands in IDLE from any state, which is what
   // aborts an access without producing a ready pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic plus the grant decision. On a tie the requester that
   // was not served last wins; lastGrantD resets to "fetch" so the data
   // side wins the first conflict. The counter reaching MEM_LAT marks the
   // edge at which the memory's read data is valid.
   always_comb begin
      grantValid = bus.if_req | bus.d_req;
      grantD     = bus.d_req & (~bus.if_req | ~lastGrantD);
      captureNow = (state == ACCESS) && (cnt == LatLast);
      nextState  = state;
      case (state)
         IDLE: begin
            if (grantValid) begin
               nextState = ACCESS;
            end
         end
         ACCESS: begin
            if (captureNow) begin
               nextState = DONE;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath registers. The winner's request is latched at grant so the
   // memory sees a stable address/data from the issue cycle through DONE no
   // matter what the requester does afterwards. Fetches always go out as
   // reads with zero byte enables. Stores never touch d_rdata.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         ownerD     <= 1'b0;
         lastGrantD <= 1'b0;
         memAddr    <= '0;
         memWe      <= 1'b0;
         memWdata   <= '0;
         memWstrb   <= '0;
         ifRdata    <= '0;
         dRdata     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grantValid) begin
                  cnt        <= '0;
                  ownerD     <= grantD;
                  lastGrantD <= grantD;
                  if (grantD) begin
                     memAddr  <= bus.d_addr;
                     memWe    <= bus.d_we;
                     memWdata <= bus.d_wdata;
                     memWstrb <= bus.d_wstrb;
                  end else begin
                     memAddr  <= bus.if_addr;
                     memWe    <= 1'b0;
                     memWdata <= '0;
                     memWstrb <= '0;
                  end
               end
            end
            ACCESS: begin
               if (captureNow) begin
                  if (!ownerD) begin
                     ifRdata <= bus.mem_rdata;
                  end else if (!memWe) begin
                     dRdata <= bus.mem_rdata;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs. The counter is cleared at grant and MEM_LAT is at least one,
   // so "ACCESS with count zero" is exactly the issue cycle. Readies come
   // from DONE and the owner bit, so only one of them can ever be high.
   always_comb begin
      ifReadyC      = (state == DONE) && !ownerD;
      dReadyC       = (state == DONE) && ownerD;
      bus.if_ready  = ifReadyC;
      bus.d_ready   = dReadyC;
      bus.stall_if  = bus.if_req & ~ifReadyC;
      bus.stall_mem = bus.d_req & ~dReadyC;
      bus.mem_en    = (state == ACCESS) && (cnt == 4'd0);
      bus.mem_we    = memWe;
      bus.mem_addr  = memAddr;
      bus.mem_wdata = memWdata;
      bus.mem_wstrb = memWstrb;
      bus.if_rdata  = ifRdata;
      bus.d_rdata   = dRdata;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A behavioural memory answers
// mem_en strobes MEM_LAT cycles later (random garbage on mem_rdata at all
// other times). A reference model works per transaction: who wins, in which
// relative cycle each access issues and completes, and what word each
// fetch/load must return, from a word-level copy of memory contents.
module tb_mem_port_arbiter;

   localparam int LAT = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int errors = 0;

   logic [31:0] envMem [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];
   int          pendCnt = 0;
   logic [31:0] pendData;
   logic [31:0] refIfRdata;
   logic [31:0] refDRdata;
   bit          refLastGrantD;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Initial memory contents, shared definition for both memory copies.
   function automatic logic [31:0] initWord(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0050_0093;
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = oldW;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[b*8 +: 8] = newW[b*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : initWord(a);
   endfunction

   // Behavioural memory: a strobe seen in cycle c makes its read word
   // appear on mem_rdata during cycle c+LAT only; stores update contents.
   always @(negedge clk) begin
      logic [31:0] w;
      bus.mem_rdata = $urandom;
      if (pendCnt > 0) begin
         pendCnt = pendCnt - 1;
         if (pendCnt == 0) bus.mem_rdata = pendData;
      end
      if (bus.mem_en === 1'b1) begin
         w = envMem.exists(bus.mem_addr) ? envMem[bus.mem_addr] : initWord(bus.mem_addr);
         if (bus.mem_we === 1'b1) envMem[bus.mem_addr] = mergeBytes(w, bus.mem_wdata, bus.mem_wstrb);
         pendData = w;
         pendCnt  = LAT;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " mem_en"},    32'(bus.mem_en),    32'd0);
      checkOutput({tag, " mem_we"},    32'(bus.mem_we),    32'd0);
      checkOutput({tag, " mem_addr"},  bus.mem_addr,       32'd0);
      checkOutput({tag, " mem_wdata"}, bus.mem_wdata,      32'd0);
      checkOutput({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
      checkOutput({tag, " if_ready"},  32'(bus.if_ready),  32'd0);
      checkOutput({tag, " d_ready"},   32'(bus.d_ready),   32'd0);
      checkOutput({tag, " if_rdata"},  bus.if_rdata,       32'd0);
      checkOutput({tag, " d_rdata"},   bus.d_rdata,        32'd0);
   endtask

   // One request episode: fetch and/or data request raised together in an
   // idle cycle (t=0) and held until their ready. Every cycle is compared
   // against the reference timeline. With scramble set, the owner's inputs
   // are randomised while its access is in flight.
   task automatic applyStimulus(input bit reqIf, input bit reqD, input logic [31:0] ifAddr,
                                input bit dWe, input logic [31:0] dAddr, input logic [31:0] dWdata,
                                input logic [3:0] dStrb, input string tag, input bit scramble);
      int          issueT [2];
      int          readyT [2];
      bit          ownD   [2];
      logic [31:0] slotAddr [2];
      logic [31:0] expData  [2];
      int          nSlots;
      int          lastT;
      bit          ifHeld;
      bit          dHeld;

      nSlots  = int'(reqIf) + int'(reqD);
      ownD[0] = reqD && (!reqIf || !refLastGrantD);
      ownD[1] = !ownD[0];
      for (int s = 0; s < nSlots; s++) begin
         issueT[s]   = 1 + s * (LAT + 3);
         readyT[s]   = issueT[s] + LAT + 1;
         slotAddr[s] = ownD[s] ? dAddr : ifAddr;
         expData[s]  = refRead(slotAddr[s]);
         if (ownD[s] && dWe) refMem[dAddr] = mergeBytes(expData[s], dWdata, dStrb);
      end
      refLastGrantD = ownD[nSlots-1];
      lastT         = readyT[nSlots-1];

      @(negedge clk);
      bus.if_req  = reqIf;
      bus.if_addr = ifAddr;
      bus.d_req   = reqD;
      bus.d_we    = dWe;
      bus.d_addr  = dAddr;
      bus.d_wdata = dWdata;
      bus.d_wstrb = dStrb;
      ifHeld      = reqIf;
      dHeld       = reqD;

      for (int t = 0; t <= lastT; t++) begin
         bit expEn;
         bit expIfRdy;
         bit expDRdy;
         int cur;
         string tt;
         if (t > 0) @(negedge clk);
         #1;
         expEn    = 1'b0;
         expIfRdy = 1'b0;
         expDRdy  = 1'b0;
         cur      = -1;
         tt       = $sformatf("%s t=%0d", tag, t);
         for (int s = 0; s < nSlots; s++) begin
            if (t == issueT[s]) expEn = 1'b1;
            if (t >= issueT[s] && t <= readyT[s]) cur = s;
            if (t == readyT[s]) begin
               if (ownD[s]) begin
                  expDRdy = 1'b1;
                  if (!dWe) refDRdata = expData[s];
               end else begin
                  expIfRdy   = 1'b1;
                  refIfRdata = expData[s];
               end
            end
         end
         checkOutput({tt, " mem_en"},    32'(bus.mem_en),    32'(expEn));
         checkOutput({tt, " if_ready"},  32'(bus.if_ready),  32'(expIfRdy));
         checkOutput({tt, " d_ready"},   32'(bus.d_ready),   32'(expDRdy));
         checkOutput({tt, " stall_if"},  32'(bus.stall_if),  32'(ifHeld && !expIfRdy));
         checkOutput({tt, " stall_mem"}, 32'(bus.stall_mem), 32'(dHeld && !expDRdy));
         checkOutput({tt, " if_rdata"},  bus.if_rdata,       refIfRdata);
         checkOutput({tt, " d_rdata"},   bus.d_rdata,        refDRdata);
         if (cur >= 0) begin
            checkOutput({tt, " mem_addr"},  bus.mem_addr,       slotAddr[cur]);
            checkOutput({tt, " mem_we"},    32'(bus.mem_we),    32'(ownD[cur] && dWe));
            checkOutput({tt, " mem_wstrb"}, 32'(bus.mem_wstrb), ownD[cur] ? 32'(dStrb) : 32'd0);
            if (ownD[cur] && dWe) checkOutput({tt, " mem_wdata"}, bus.mem_wdata, dWdata);
         end
         if (expIfRdy) begin
            ifHeld     = 1'b0;
            bus.if_req = 1'b0;
         end
         if (expDRdy) begin
            dHeld     = 1'b0;
            bus.d_req = 1'b0;
         end
         if (scramble && cur >= 0 && t > issueT[cur] && t < readyT[cur]) begin
            if (ownD[cur]) begin
               bus.d_addr  = $urandom;
               bus.d_wdata = $urandom;
               bus.d_wstrb = 4'($urandom);
               bus.d_we    = 1'($urandom);
            end else begin
               bus.if_addr = $urandom;
            end
         end
      end
   endtask

   // Directed scenarios first, then randomised request mixes.
   initial begin
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.d_wstrb   = '0;
      bus.mem_rdata = '0;
      refIfRdata    = '0;
      refDRdata     = '0;
      refLastGrantD = 1'b0;

      repeat (3) @(negedge clk);
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      #1;
      checkResetState("reset");
      checkOutput("reset stall_if",  32'(bus.stall_if),  32'd1);
      checkOutput("reset stall_mem", 32'(bus.stall_mem), 32'd1);
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      #1;
      checkOutput("reset stall_if low",  32'(bus.stall_if),  32'd0);
      checkOutput("reset stall_mem low", 32'(bus.stall_mem), 32'd0);
      rst = 1'b0;

      applyStimulus(1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_2000, 32'h0, 4'h0, "conflictD", 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0, "fetch", 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, "store", 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0108, 1'b0, 32'h0000_2004, 32'h0, 4'h0, "conflictIf", 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_2000 + 32'(i) * 4, 32'h0, 4'h0,
                       $sformatf("b2b%0d", i), 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, "inchange", 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 32'h0000_2004, 32'h1122_3344, 4'b0101, "partial", 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_2004, 32'h0, 4'h0, "partialrd", 1'b0);

      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0300;
      @(negedge clk);
      #1;
      checkOutput("rstmid issue mem_en", 32'(bus.mem_en), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkResetState("rstmid");
      checkOutput("rstmid stall_if", 32'(bus.stall_if), 32'd1);
      rst           = 1'b0;
      refIfRdata    = '0;
      refDRdata     = '0;
      refLastGrantD = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rstmid reissue mem_en",   32'(bus.mem_en), 32'd1);
      checkOutput("rstmid reissue mem_addr", bus.mem_addr,    32'h0000_0300);
      for (int t = 5; t <= LAT + 5; t++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("rstmid t=%0d mem_en", t),   32'(bus.mem_en),   32'd0);
         checkOutput($sformatf("rstmid t=%0d if_ready", t), 32'(bus.if_ready), 32'(t == LAT + 5));
         if (t == LAT + 5) begin
            refIfRdata = refRead(32'h0000_0300);
            checkOutput("rstmid if_rdata", bus.if_rdata, refIfRdata);
            bus.if_req = 1'b0;
         end
      end

      for (int i = 0; i < 40; i++) begin
         int          sel;
         logic [31:0] ia;
         logic [31:0] da;
         sel = $urandom_range(1, 3);
         ia  = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 4;
         da  = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 4;
         applyStimulus(sel[0], sel[1], ia, 1'($urandom), da, $urandom, 4'($urandom),
                       $sformatf("rand%0d", i), 1'($urandom));
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
- Arbitrates between the two, sequences each fixed-latency access with a counter, returns read data, and produces the stall signals the pipeline control uses to hold PC, IF/ID and later stages while an access is outstanding.

Parameters:
- MEM_LAT, 2: memory read latency in cycles, range 1..15. mem_rdata is valid MEM_LAT cycles after the mem_en cycle.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Must be 32; mem_wstrb is 4 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; registered, held until the next fetch completes.
- if_ready  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  4  byte enables.
- d_rdata  out  DATA_W  load word; registered, held until the next data access completes.
- d_ready  out  1  one-cycle pulse: data access complete.
- stall_if  out  1  combinational: if_req & ~if_ready.
- stall_mem  out  1  combinational: d_req & ~d_ready.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_wstrb  out  4  byte enables; forced to 0 for fetches.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state IDLE, counter 0, last_grant = IF, mem_en/mem_we 0, mem_addr/mem_wdata/mem_wstrb 0, if_rdata/d_rdata 0, if_ready/d_ready 0.
- States:
  - IDLE: no access outstanding.
  - ACCESS: access in flight; owner register = IF or D.
  - DONE: single cycle in which the ready pulse is driven.
- IDLE → ACCESS, at an edge with any request high:
  - Only one request: grant it.
  - Both requests: grant the one that is not last_grant. After reset, D wins the first conflict.
  - Register mem_addr, mem_we, mem_wdata and mem_wstrb from the granted requester. Fetch forces we = 0 and wstrb = 0.
  - Set mem_en = 1 for exactly the next cycle (the issue cycle). Set last_grant = owner. Clear the counter.
- ACCESS:
  - Counter increments each cycle after the issue cycle.
  - At the edge ending the MEM_LAT-th cycle after the issue cycle, capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave d_rdata unchanged). Go to DONE.
- DONE: assert the owner's ready for exactly one cycle, then return to IDLE.
- Latency: issue in cycle N, ready in cycle N+MEM_LAT+1.
- Throughput: the earliest next issue is the cycle after DONE, so a new access starts at most every MEM_LAT+3 cycles.
- mem_addr, mem_we, mem_wdata and mem_wstrb stay stable from the issue cycle through DONE. Requester inputs are ignored after grant.
- Requests dropped mid-access are a protocol violation. The access still completes and ready still pulses.
- if_ready and d_ready are never high in the same cycle.
- rst in any state aborts the access:
  - Next cycle: all reset values, no ready pulse.
  - A request held across reset deassertion is granted at the first edge with rst low.
- stall_if and stall_mem follow their equations combinationally, including during reset (readies are 0, so stall equals req).

Test Plan:
- Single fetch, MEM_LAT=2: if_req at edge 0, if_addr=0x100, memory returns 0x00500093 → mem_en high cycle 1 with mem_addr=0x100 and mem_wstrb=0; if_ready pulse cycle 4 with if_rdata=0x00500093; stall_if high cycles 0–3.
- Store: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF → mem_en cycle 1 with mem_we=1 and matching data/strobe; d_ready cycle 4; d_rdata unchanged.
- Conflict after reset: if_req and d_req both high at edge 0 → D granted (mem_en cycle 1, d_ready cycle 4). IF is issued in cycle 6, if_ready in cycle 9. Repeat the conflict → IF wins the next tie.
- Back-to-back loads: 3 loads, MEM_LAT=1 → issues spaced every 4 cycles, each d_rdata correct, no missing or extra ready pulses.
- Reset mid-access: rst pulsed in cycle 2 of a fetch → no if_ready, mem_en 0, if_rdata=0. With if_req held, the fetch reissues starting with mem_en one cycle after rst falls.
- Input change after grant: d_addr changed from 0x40 to 0x80 during ACCESS → mem_addr stays 0x40 until DONE.
